// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port block-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 32;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant: on a conflict the port not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept_en,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (accept_en) begin
            if (valid[PORT_D] && valid[PORT_I]) begin
                if (last_grant == PORT_I) grant[PORT_D] = 1'b1;
                else                      grant[PORT_I] = 1'b1;
            end else begin
                grant = valid;
            end
        end
    end

    // Resetting to I makes D the winner of the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_I;
        end else if (|grant) begin
            last_grant <= grant[PORT_I] ? PORT_I : PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Data/fetch arbiter and sequencer for the 4K x 32 single-port block memory.
// Optional statistics counters are enabled with `define MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_rdata,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_rdata,
    output logic [ADDR_W-1:0] mem_da,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memwrite,
    output logic              mem_memread,
    input  logic [DATA_W-1:0] mem_doa,
    output logic              busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    state_t            state;
    logic [1:0]        valid_vec;
    logic [1:0]        grant;
    logic              accept_en;
    logic              accept;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              cmd_port;
    logic              cmd_we;

    assign valid_vec = {i_req_valid, d_req_valid};
    assign accept_en = ((state == IDLE) || (state == RESP)) && !rst;

    rr_arb2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid_vec),
        .accept_en (accept_en),
        .grant     (grant)
    );

    assign d_req_ready = grant[PORT_D];
    assign i_req_ready = grant[PORT_I];
    assign accept      = |grant;

    // The fetch port is read-only, so its command never carries a write.
    assign req_we    = grant[PORT_D] & d_req_we;
    assign req_addr  = grant[PORT_D] ? d_req_addr  : i_req_addr;
    assign req_wdata = grant[PORT_D] ? d_req_wdata : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_port <= grant[PORT_I];
            cmd_we   <= req_we;
        end
    end

    // Memory pins are loaded on accept so they are live for exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mem_da         <= '0;
            mem_write_data <= '0;
            mem_memwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            d_rsp_valid    <= 1'b0;
            i_rsp_valid    <= 1'b0;
        end else begin
            case (state)
                ISSUE: begin
                    state          <= RESP;
                    mem_da         <= '0;
                    mem_write_data <= '0;
                    mem_memwrite   <= 1'b0;
                    mem_memread    <= 1'b0;
                    d_rsp_valid    <= (cmd_port == PORT_D);
                    i_rsp_valid    <= (cmd_port == PORT_I);
                end
                default: begin
                    d_rsp_valid <= 1'b0;
                    i_rsp_valid <= 1'b0;
                    if (accept) begin
                        state          <= ISSUE;
                        mem_da         <= req_addr;
                        mem_write_data <= req_wdata;
                        mem_memwrite   <= req_we;
                        mem_memread    <= ~req_we;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // doa was registered by the memory at the end of ISSUE and is steered in RESP.
    assign d_rsp_rdata = (d_rsp_valid && !cmd_we) ? mem_doa : '0;
    assign i_rsp_rdata = i_rsp_valid ? mem_doa : '0;
    assign busy        = (state != IDLE);

`ifdef MEM_ARB_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            d_grant_cnt  <= '0;
            i_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant[PORT_D])         d_grant_cnt  <= sat_inc(d_grant_cnt);
            if (grant[PORT_I])         i_grant_cnt  <= sat_inc(i_grant_cnt);
            if (accept && &valid_vec)  conflict_cnt <= sat_inc(conflict_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences and
// a randomized run against a transaction-level model with a behavioural memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_req_valid = 1'b0, d_req_we = 1'b0;
    logic [11:0] d_req_addr = '0;
    logic [31:0] d_req_wdata = '0;
    logic        d_req_ready, d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        i_req_valid = 1'b0;
    logic [11:0] i_req_addr = '0;
    logic        i_req_ready, i_rsp_valid;
    logic [31:0] i_rsp_rdata;
    logic [11:0] mem_da;
    logic [31:0] mem_write_data;
    logic        mem_memwrite, mem_memread;
    logic [31:0] mem_doa = '0;
    logic        busy;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef MEM_ARB_STATS_EN
    logic [CW-1:0] d_grant_cnt, i_grant_cnt, conflict_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
        .mem_da(mem_da), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_doa(mem_doa), .busy(busy)
`ifdef MEM_ARB_STATS_EN
        , .d_grant_cnt(d_grant_cnt), .i_grant_cnt(i_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    // Block memory: read registered on posedge, write committed on negedge.
    logic [31:0] mem [4096];
    always @(posedge clk) if (mem_memread) mem_doa <= mem[mem_da];
    always @(negedge clk) if (mem_memwrite) mem[mem_da] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic d_issue(input logic we, input logic [11:0] addr, input logic [31:0] wd);
        logic seen;
        seen = 1'b0;
        d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wd;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d_req_ready) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("d_accept", seen, 1'b1);
        tick();
        d_req_valid = 1'b0;
        tick();
    endtask

    task automatic d_write(input logic [11:0] addr, input logic [31:0] wd);
        d_issue(1'b1, addr, wd);
        tick();
    endtask

    task automatic d_read(input logic [11:0] addr, input logic [31:0] exp);
        d_issue(1'b0, addr, '0);
        @(negedge clk);
        chk("d_read_valid", d_rsp_valid, 1'b1);
        chk("d_read_data", d_rsp_rdata, exp);
        tick();
    endtask

    typedef struct {
        logic dv; logic dwe; logic [11:0] dad; logic [31:0] dwd; logic iv; logic [11:0] iad;
        logic e_dr; logic e_ir; logic e_drv; logic [31:0] e_drd; logic e_irv; logic [31:0] e_ird;
        logic e_mw; logic e_mr; logic [11:0] e_mda; logic [31:0] e_mwd; logic e_busy;
    } vec_t;

    typedef struct {
        logic v; logic port_i; logic we; logic [11:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    } op_t;

    vec_t        tbl [16];
    logic [31:0] ref_mem [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{'1,'1,12'h005,32'hDEADBEEF,'0,'0, '1,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0};
        tbl[1]  = '{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0,'0, '1,'0,12'h005,32'hDEADBEEF,'1};
        tbl[2]  = '{'1,'0,12'h005,'0,'0,'0, '1,'0,'1,'0,'0,'0, '0,'0,'0,'0,'1};
        tbl[3]  = '{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0,'0, '0,'1,12'h005,'0,'1};
        tbl[4]  = '{'1,'1,12'hFFF,32'hCAFEF00D,'0,'0, '1,'0,'1,32'hDEADBEEF,'0,'0, '0,'0,'0,'0,'1};
        tbl[5]  = '{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0,'0, '1,'0,12'hFFF,32'hCAFEF00D,'1};
        tbl[6]  = '{'0,'0,'0,'0,'1,12'hFFF, '0,'1,'1,'0,'0,'0, '0,'0,'0,'0,'1};
        tbl[7]  = '{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0,'0, '0,'1,12'hFFF,'0,'1};
        tbl[8]  = '{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'1,32'hCAFEF00D, '0,'0,'0,'0,'1};
        tbl[9]  = '{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0};
        tbl[10] = '{'1,'0,12'h005,'0,'1,12'hFFF, '1,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0};
        tbl[11] = '{'0,'0,'0,'0,'1,12'hFFF, '0,'0,'0,'0,'0,'0, '0,'1,12'h005,'0,'1};
        tbl[12] = '{'0,'0,'0,'0,'1,12'hFFF, '0,'1,'1,32'hDEADBEEF,'0,'0, '0,'0,'0,'0,'1};
        tbl[13] = '{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0,'0, '0,'1,12'hFFF,'0,'1};
        tbl[14] = '{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'1,32'hCAFEF00D, '0,'0,'0,'0,'1};
        tbl[15] = '{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.d_ready", d_req_ready, 1'b0);
        chk("rst.i_ready", i_req_ready, 1'b0);
        chk("rst.d_rsp", d_rsp_valid, 1'b0);
        chk("rst.i_rsp", i_rsp_valid, 1'b0);
        chk("rst.memrd", mem_memread, 1'b0);
        chk("rst.memwr", mem_memwrite, 1'b0);
        chk("rst.da", 32'(mem_da), 32'h0);
        chk("rst.d_rdata", d_rsp_rdata, 32'h0);
        chk("rst.i_rdata", i_rsp_rdata, 32'h0);
        tick();
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            d_req_valid = tbl[i].dv;  d_req_we = tbl[i].dwe;
            d_req_addr  = tbl[i].dad; d_req_wdata = tbl[i].dwd;
            i_req_valid = tbl[i].iv;  i_req_addr = tbl[i].iad;
            @(negedge clk);
            chk($sformatf("r%0d.d_ready", i), d_req_ready, tbl[i].e_dr);
            chk($sformatf("r%0d.i_ready", i), i_req_ready, tbl[i].e_ir);
            chk($sformatf("r%0d.d_rsp", i), d_rsp_valid, tbl[i].e_drv);
            chk($sformatf("r%0d.d_rdata", i), d_rsp_rdata, tbl[i].e_drd);
            chk($sformatf("r%0d.i_rsp", i), i_rsp_valid, tbl[i].e_irv);
            chk($sformatf("r%0d.i_rdata", i), i_rsp_rdata, tbl[i].e_ird);
            chk($sformatf("r%0d.memwr", i), mem_memwrite, tbl[i].e_mw);
            chk($sformatf("r%0d.memrd", i), mem_memread, tbl[i].e_mr);
            chk($sformatf("r%0d.da", i), 32'(mem_da), 32'(tbl[i].e_mda));
            chk($sformatf("r%0d.wdata", i), mem_write_data, tbl[i].e_mwd);
            chk($sformatf("r%0d.busy", i), busy, tbl[i].e_busy);
            tick();
        end
        d_req_valid = 1'b0; i_req_valid = 1'b0;

        // Continuous conflict: D took the last grant, so I leads and they alternate
        d_write(12'h100, 32'h12345678);
        d_write(12'h200, 32'h0BADF00D);
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 12'h200; d_req_wdata = '0;
        i_req_valid = 1'b1; i_req_addr = 12'h100;
        for (int k = 0; k < 9; k++) begin
            logic w_i, p_i;
            w_i = ((k / 2) % 2 == 0);
            if (k == 8) begin
                d_req_valid = 1'b0; i_req_valid = 1'b0;
            end
            @(negedge clk);
            if (k % 2 == 0 && k < 8) begin
                chk("cf.d_ready", d_req_ready, !w_i);
                chk("cf.i_ready", i_req_ready, w_i);
            end
            if (k % 2 == 1) begin
                chk("cf.ready_in_issue", {d_req_ready, i_req_ready}, 2'b00);
                chk("cf.da", 32'(mem_da), w_i ? 32'h100 : 32'h200);
            end
            if (k % 2 == 0 && k >= 2) begin
                p_i = (((k - 2) / 2) % 2 == 0);
                chk("cf.i_rsp", i_rsp_valid, p_i);
                chk("cf.d_rsp", d_rsp_valid, !p_i);
                chk("cf.i_rdata", i_rsp_rdata, p_i ? 32'h12345678 : 32'h0);
                chk("cf.d_rdata", d_rsp_rdata, p_i ? 32'h0 : 32'h0BADF00D);
            end
            tick();
        end

        // Reset during the ISSUE cycle of a write: write lands, no response
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 12'h010; d_req_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("ri.d_ready", d_req_ready, 1'b1);
        tick();
        d_req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("ri.memwr", mem_memwrite, 1'b1);
        chk("ri.da", 32'(mem_da), 32'h010);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ri.d_rsp", d_rsp_valid, 1'b0);
        chk("ri.busy", busy, 1'b0);
        tick();
        d_read(12'h010, 32'hA5A5A5A5);

        // Seed the random window, then reset so arbitration and counters start fresh
        for (int j = 0; j < 16; j++) begin
            ref_mem[j] = $urandom;
            d_write(12'h300 | 12'(j), ref_mem[j]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;

        begin
            op_t iss, rsp, nxt;
            logic last_is_i, d_win, i_win;
            int m_d, m_i, m_c;
            iss = '{default: '0}; rsp = '{default: '0};
            last_is_i = 1'b1; m_d = 0; m_i = 0; m_c = 0;
            for (int c = 0; c < 1500; c++) begin
                if (!d_req_valid && $urandom_range(0, 2) == 0) begin
                    d_req_valid = 1'b1; d_req_we = 1'($urandom_range(0, 1));
                    d_req_addr = {8'h30, 4'($urandom_range(0, 15))}; d_req_wdata = $urandom;
                end
                if (!i_req_valid && $urandom_range(0, 2) == 0) begin
                    i_req_valid = 1'b1; i_req_addr = {8'h30, 4'($urandom_range(0, 15))};
                end
                @(negedge clk);
                d_win = !iss.v && d_req_valid && (!i_req_valid || last_is_i);
                i_win = !iss.v && i_req_valid && !d_win;
                chk("rnd.d_ready", d_req_ready, d_win);
                chk("rnd.i_ready", i_req_ready, i_win);
                chk("rnd.busy", busy, iss.v || rsp.v);
                chk("rnd.memrd", mem_memread, iss.v && !iss.we);
                chk("rnd.memwr", mem_memwrite, iss.v && iss.we);
                chk("rnd.da", 32'(mem_da), iss.v ? 32'(iss.addr) : 32'h0);
                if (iss.v && iss.we) chk("rnd.wdata", mem_write_data, iss.wdata);
                chk("rnd.d_rsp", d_rsp_valid, rsp.v && !rsp.port_i);
                chk("rnd.i_rsp", i_rsp_valid, rsp.v && rsp.port_i);
                chk("rnd.d_rdata", d_rsp_rdata, (rsp.v && !rsp.port_i && !rsp.we) ? rsp.rdata : 32'h0);
                chk("rnd.i_rdata", i_rsp_rdata, (rsp.v && rsp.port_i) ? rsp.rdata : 32'h0);
`ifdef MEM_ARB_STATS_EN
                chk("rnd.d_grant_cnt", 32'(d_grant_cnt), 32'(m_d));
                chk("rnd.i_grant_cnt", 32'(i_grant_cnt), 32'(m_i));
                chk("rnd.conflict_cnt", 32'(conflict_cnt), 32'(m_c));
`endif
                if (iss.v) begin
                    if (iss.we) ref_mem[iss.addr[3:0]] = iss.wdata;
                    else        iss.rdata = ref_mem[iss.addr[3:0]];
                end
                nxt = '{default: '0};
                if (d_win) nxt = '{1'b1, 1'b0, d_req_we, d_req_addr, d_req_wdata, 32'h0};
                if (i_win) nxt = '{1'b1, 1'b1, 1'b0, i_req_addr, 32'h0, 32'h0};
                rsp = iss; iss = nxt;
                if (d_win || i_win) last_is_i = i_win;
                if (d_win && m_d < (1 << 16) - 1) m_d++;
                if (i_win && m_i < (1 << 16) - 1) m_i++;
                if ((d_win || i_win) && d_req_valid && i_req_valid && m_c < (1 << 16) - 1) m_c++;
`ifdef MEM_ARB_STATS_EN
                if (m_d > CMAX) m_d = CMAX;
                if (m_i > CMAX) m_i = CMAX;
                if (m_c > CMAX) m_c = CMAX;
`endif
                tick();
                if (d_win || (d_req_valid && $urandom_range(0, 19) == 0)) d_req_valid = 1'b0;
                if (i_win || (i_req_valid && $urandom_range(0, 19) == 0)) i_req_valid = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the 4K x 32 single-port block memory (12-bit word address, read data registered on posedge, write committed on negedge).
- Requester D is the data path (load/store, read/write); requester I is instruction fetch (read-only).
- Owns the memory's da/write_data/memwrite/memread pins and returns doa to the granted requester with valid/ready request handshakes and fixed-latency responses.

Parameters:
ADDR_W, 12, word address width; must match the memory depth (2^ADDR_W words).
DATA_W, 32, data word width.
CNT_W, 16, width of statistics counters (only used with MEM_ARB_STATS_EN).

Ports:
clk  in  1  system clock; all state on posedge.
rst  in  1  synchronous active-high reset.
d_req_valid  in  1  data request present.
d_req_we  in  1  1 = write, 0 = read.
d_req_addr  in  ADDR_W  data word address.
d_req_wdata  in  DATA_W  store data.
d_req_ready  out  1  data request accepted this cycle.
d_rsp_valid  out  1  one-cycle pulse: data op complete (read data valid or write done).
d_rsp_rdata  out  DATA_W  read data; 0 for writes.
i_req_valid  in  1  fetch request present.
i_req_addr  in  ADDR_W  fetch word address.
i_req_ready  out  1  fetch request accepted this cycle.
i_rsp_valid  out  1  one-cycle pulse: fetch data valid.
i_rsp_rdata  out  DATA_W  fetched word.
mem_da  out  ADDR_W  to memory da.
mem_write_data  out  DATA_W  to memory write_data.
mem_memwrite  out  1  to memory memwrite.
mem_memread  out  1  to memory memread.
mem_doa  in  DATA_W  from memory doa.
busy  out  1  high while state != IDLE.

Behaviour:
- FSM states IDLE, ISSUE, RESP. Reset value is IDLE.
- Reset values: all outputs 0 except rdata buses, which are 0. last_grant resets to I, so D wins the first conflict.
- Accept: possible in IDLE or RESP only. Never in ISSUE: both readies are 0 there.
  - One requester valid: it gets ready=1 in the same cycle (ready is combinational from valid and state).
  - Both valid: round-robin. The port not granted last wins. last_grant is updated on every accept.
  - At most one ready is high per cycle.
- On accept: capture port id, we, addr and wdata into command registers, then go to ISSUE.
- ISSUE (1 cycle):
  - mem_da = cmd_addr.
  - mem_memread = !cmd_we; mem_memwrite = cmd_we; mem_write_data = cmd_wdata.
  - Write commits at this cycle's negedge. Read data is registered by the memory at the closing posedge.
  - Next state is RESP.
- RESP (1 cycle):
  - The granted port's rsp_valid = 1. rsp_rdata = mem_doa for reads, 0 for writes.
  - The other port's rsp_valid = 0.
  - Next state is ISSUE if a new request is accepted this cycle, else IDLE.
- Memory pins outside ISSUE: memread = memwrite = 0, da/write_data = 0. doa therefore holds its last value.
- Latency: request accept at cycle N, memory access at N+1, rsp_valid at N+2.
- Throughput: back-to-back one op per 2 cycles.
- Responses have no backpressure; requesters must sample rsp in the RESP cycle.
- I port never asserts memwrite.
- Read-after-write: a D write at N followed by a D read of the same address at N+2 returns the new data, because the write committed at the negedge of N+1.
- Request inputs are held by the requester until ready. A dropped valid before ready is legal: no effect.
- rst in IDLE/RESP: next state IDLE, any accept in that cycle is discarded, no response.
- rst asserted during ISSUE: the write already driven still commits at that negedge. Next state IDLE, no response pulse.

Optional Feature:
Macro MEM_ARB_STATS_EN.
- Defined: adds outputs d_grant_cnt, i_grant_cnt, conflict_cnt (each CNT_W).
  - Each grant counter increments on its port's accept.
  - conflict_cnt increments on any accept cycle with both valids high.
  - All three saturate at all-ones and clear on rst.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE/ISSUE/RESP);
  - the port-id constants PORT_D=0 and PORT_I=1;
  - the default ADDR_W/DATA_W.
- One sub-module, rr_arb2: two-input round-robin grant logic with last_grant register. Its inputs are valid pair and accept enable; its outputs are one-hot grant.
- FSM, command registers and memory pin drive stay in mem_arbiter.

Test Plan:
- Reset then D write addr 0x005 data 0xDEADBEEF → d_req_ready same cycle, mem_memwrite=1 next cycle with mem_da=0x005, d_rsp_valid two cycles after accept with rdata 0.
- D read addr 0x005 immediately in the write's RESP cycle → accepted that cycle; d_rsp_rdata=0xDEADBEEF 2 cycles later.
- D and I both valid continuously (I addr 0x100 preloaded 0x12345678) → grants alternate D,I,D,I each 2 cycles. The I response is 0x12345678 and is never on d_rsp.
- Single I fetch of 0xFFF (top wrap address) → mem_memread=1, mem_da=0xFFF, mem_memwrite never 1; i_rsp_valid after 2 cycles.
- rst asserted in the ISSUE cycle of a D write to 0x010 data 0xA5A5A5A5 → no d_rsp_valid, busy=0 next cycle. A later read of 0x010 returns 0xA5A5A5A5.
- With MEM_ARB_STATS_EN: 3 D-only ops then 4 conflicting cycles → d_grant_cnt and i_grant_cnt match the grant log, conflict_cnt=4. Force a counter to 0xFFFF and grant again → it stays 0xFFFF.
